// File: rtl/adc_capture_buffer_pkg.sv
// adc_cap_pkg: capture states, sample/word widths and RAM word packing for adc_capture_buffer
package adc_cap_pkg;
  typedef enum logic [1:0] {IDLE, FLUSH, CAPTURE, DONE} capState_e;
  localparam int ADC_DATA_W = 12;
  localparam int WORD_W = 16;
  function automatic logic [WORD_W-1:0] packWord(input logic otr, input logic [ADC_DATA_W-1:0] data);
    return {otr, 3'b000, data};
  endfunction
endpackage

// File: rtl/adc_capture_buffer_clk_div.sv
// adc_clk_div: divided ADC conversion clock plus a strobe in the cycle before each rising edge
module adc_clk_div #(
  parameter int DIV_W = 11
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enable,
  input  logic [DIV_W-1:0] divLat,
  output logic             adcClk,
  output logic             sampStb
);
  logic [DIV_W-1:0] divCnt;
  logic wrap;
  assign wrap = divCnt == divLat;
  assign sampStb = wrap && !adcClk;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      divCnt <= '0;
      adcClk <= 1'b0;
    end else if (!enable) begin
      divCnt <= '0;
      adcClk <= 1'b0;
    end else begin
      divCnt <= wrap ? '0 : divCnt + 1'b1;
      adcClk <= adcClk ^ wrap;
    end
endmodule

// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: ADC clock generation, one-burst capture into a 2**ADDR_W x 16 RAM, registered read port.
// Define ADC_OTR_CLAMP_EN to saturate out-of-range samples to full scale by ADC_BIT[11].
module adc_capture_buffer
  import adc_cap_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int SAMPLE_NUM = 1024,
  parameter int PIPE_DELAY = 7,
  parameter int DIV_W      = 11
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START_TURN,
  input  logic [DIV_W-1:0]      DIVIDER,
  input  logic [ADC_DATA_W-1:0] ADC_BIT,
  input  logic                  ADC_OTR,
  output logic                  ADC_CLK,
  output logic                  ADC_OE,
  input  logic [ADDR_W-1:0]     RAM_RD_ADDR,
  output logic [WORD_W-1:0]     RAM_DATA_OUT,
  output logic                  TURN_DONE,
  output logic                  BUSY
);
  localparam int FLUSH_W = $clog2(PIPE_DELAY + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(PIPE_DELAY - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SAMPLE_NUM - 1);
  capState_e state, stateNext;
  logic [DIV_W-1:0] divLat;
  logic [FLUSH_W-1:0] flushCnt;
  logic [ADDR_W-1:0] wrAddr;
  logic run, sampStb, wrEn, lastWr;
  logic [ADC_DATA_W-1:0] sampData;
  logic [WORD_W-1:0] mem [2**ADDR_W];
  assign run = state == FLUSH || state == CAPTURE;
  assign wrEn = state == CAPTURE && sampStb;
  assign lastWr = wrEn && wrAddr == ADDR_LAST;
  assign BUSY = run;
  assign ADC_OE = !run;
  assign TURN_DONE = state == DONE;
  // Dropping enable on the final strobe keeps ADC_CLK parked low from the last sample onward.
  adc_clk_div #(.DIV_W(DIV_W)) uClkDiv (
    .CLK(CLK),
    .RST(RST),
    .enable(run && !lastWr),
    .divLat(divLat),
    .adcClk(ADC_CLK),
    .sampStb(sampStb)
  );
`ifdef ADC_OTR_CLAMP_EN
  assign sampData = ADC_OTR ? {ADC_DATA_W{ADC_BIT[ADC_DATA_W-1]}} : ADC_BIT;
`else
  assign sampData = ADC_BIT;
`endif
  always_comb
    stateNext = (state == IDLE && START_TURN) ? FLUSH :
                (state == FLUSH && sampStb && flushCnt == FLUSH_LAST) ? CAPTURE :
                lastWr ? DONE :
                (state == DONE) ? IDLE : state;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= IDLE;
      divLat <= '0;
      flushCnt <= '0;
      wrAddr <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && START_TURN) begin
        divLat <= DIVIDER;
        flushCnt <= '0;
        wrAddr <= '0;
      end
      if (state == FLUSH && sampStb) flushCnt <= flushCnt + 1'b1;
      if (wrEn && !lastWr) wrAddr <= wrAddr + 1'b1;
    end
  always_ff @(posedge CLK)
    if (wrEn) mem[wrAddr] <= packWord(ADC_OTR, sampData);
  always_ff @(posedge CLK or negedge RST)
    if (!RST) RAM_DATA_OUT <= '0;
    else RAM_DATA_OUT <= mem[RAM_RD_ADDR];
endmodule

// File: tb/tb_adc_capture_buffer.sv
// tb_adc_capture_buffer: arithmetic burst model plus directed scenarios for adc_capture_buffer
module tb_adc_capture_buffer;
  localparam int PD = 7;
  localparam int SN = 1024;
  localparam int STB = PD + SN;
  logic CLK = 0, RST = 0, START_TURN = 0, ADC_OTR = 0;
  logic [10:0] DIVIDER = 0;
  logic [11:0] ADC_BIT = 0;
  logic [9:0] RAM_RD_ADDR = 0;
  logic ADC_CLK, ADC_OE, TURN_DONE, BUSY;
  logic [15:0] RAM_DATA_OUT;
  int nAssert = 0, nFail = 0;
  int cyc = 0, startCyc = 0, doneSeen = 0, rises = 0;
  int base = 0, otrPer = -1;
  bit chkOn = 0, prevClk = 0;
  int mActive = 0, mN = 0, mL = 0;
  logic [15:0] expMem [SN];

  adc_capture_buffer dut (
    .CLK(CLK), .RST(RST), .START_TURN(START_TURN), .DIVIDER(DIVIDER),
    .ADC_BIT(ADC_BIT), .ADC_OTR(ADC_OTR), .ADC_CLK(ADC_CLK), .ADC_OE(ADC_OE),
    .RAM_RD_ADDR(RAM_RD_ADDR), .RAM_DATA_OUT(RAM_DATA_OUT),
    .TURN_DONE(TURN_DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    nAssert++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] expWord(input logic otr, input logic [11:0] d);
`ifdef ADC_OTR_CLAMP_EN
    if (otr) d = {12{d[11]}};
`endif
    return {otr, 3'b000, d};
  endfunction

  function automatic int lastEdge(input int l);
    return (l + 1) * (2 * STB - 1);
  endfunction

  // Model: n edges after acceptance; ADC_CLK toggles every L+1 edges, sample k lands on edge (L+1)(2k-1).
  always @(posedge CLK or negedge RST) begin
    int n, k;
    if (!RST) mActive <= 0;
    else if (mActive != 0) begin
      if (mN == lastEdge(mL)) mActive <= 0;
      else begin
        n = mN + 1;
        mN <= n;
        if (n % (mL + 1) == 0 && (n / (mL + 1)) % 2 == 1) begin
          k = (n / (mL + 1) + 1) / 2;
          if (k > PD) expMem[k - PD - 1] <= expWord(ADC_OTR, ADC_BIT);
        end
      end
    end else if (START_TURN) begin
      mActive <= 1;
      mN <= 0;
      mL <= int'(DIVIDER);
    end
  end

  always @(negedge CLK) begin
    bit eBusy;
    if (RST && chkOn) begin
      eBusy = mActive != 0 && mN < lastEdge(mL);
      chk("busy", BUSY, eBusy);
      chk("adc_oe", ADC_OE, !eBusy);
      chk("turn_done", TURN_DONE, mActive != 0 && mN == lastEdge(mL));
      chk("adc_clk", ADC_CLK, eBusy && (mN / (mL + 1)) % 2 == 1);
      if (TURN_DONE) doneSeen++;
      if (ADC_CLK && !prevClk) rises++;
    end
    prevClk = ADC_CLK;
  end

  initial forever begin
    int p;
    @(negedge CLK);
    p = mN / (2 * (mL + 1));
    ADC_OTR = (p == otrPer);
    ADC_BIT = (p == otrPer) ? 12'h9AB : 12'(base + p);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic startBurst(input int div);
    @(negedge CLK);
    DIVIDER = 11'(div);
    START_TURN = 1;
    startCyc = cyc;
    @(negedge CLK);
    START_TURN = 0;
  endtask

  task automatic waitDone(input int budget, input int latency);
    int t = 0;
    while (!TURN_DONE && t < budget) begin
      @(negedge CLK);
      t++;
    end
    chk("done_seen", TURN_DONE, 1);
    chk("done_latency", cyc - startCyc, latency);
  endtask

  task automatic readback();
    for (int a = 0; a <= SN; a++) begin
      @(negedge CLK);
      if (a > 0) chk($sformatf("rd_word[%0d]", a - 1), RAM_DATA_OUT, expMem[a - 1]);
      if (a < SN) RAM_RD_ADDR = 10'(a);
    end
  endtask

  initial begin
    int d0, r0;
    tick(3);
    chk("rst_adc_clk", ADC_CLK, 0);
    chk("rst_adc_oe", ADC_OE, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", TURN_DONE, 0);
    chk("rst_ram_out", RAM_DATA_OUT, 0);
    RST = 1;
    chkOn = 1;
    tick(3);

    base = 'h100;
    r0 = rises;
    startBurst(0);
    waitDone(3000, 2 * STB);
    tick(2);
    chk("rises_div0", rises - r0, STB - 1);
    chk("pin_mem0", expMem[0], 16'h0107);
    chk("pin_mem1023", expMem[SN - 1], 16'h0506);
    readback();

    base = 'h200;
    otrPer = PD + 100;
    r0 = rises;
    d0 = doneSeen;
    startBurst(3);
    tick(200);
    DIVIDER = 0;
    tick(800);
    START_TURN = 1;
    @(negedge CLK);
    START_TURN = 0;
    waitDone(9000, 4 * (2 * STB - 1) + 1);
    tick(20);
    chk("single_done", doneSeen - d0, 1);
    chk("rises_div3", rises - r0, STB - 1);
`ifdef ADC_OTR_CLAMP_EN
    chk("pin_otr_word", expMem[100], 16'h8FFF);
`else
    chk("pin_otr_word", expMem[100], 16'h89AB);
`endif
    chk("pin_mem101", expMem[101], 16'h026C);
    readback();

    otrPer = -1;
    base = 'h300;
    d0 = doneSeen;
    startBurst(0);
    tick(500);
    #1 RST = 0;
    #1;
    chk("arst_adc_clk", ADC_CLK, 0);
    chk("arst_adc_oe", ADC_OE, 1);
    chk("arst_busy", BUSY, 0);
    chk("arst_done", TURN_DONE, 0);
    chk("arst_ram_out", RAM_DATA_OUT, 0);
    tick(5);
    RST = 1;
    tick(30);
    chk("no_done_after_rst", doneSeen - d0, 0);
    base = 'h400;
    startBurst(0);
    waitDone(3000, 2 * STB);
    tick(2);
    chk("pin_mem0_b3", expMem[0], 16'h0407);
    readback();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
